core_trace_buf: RTL and testbench

CORE_TRACE_BUF -- requirements
Module: core_trace_buf

---
 rtl/core_pkg.sv | 22 ++
 rtl/core_trace_fifo.sv | 49 ++++
 rtl/core_trace_buf.sv | 106 ++++++++++
 tb/tb_core_trace_buf.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types for the retirement trace buffer: the trace entry layout and the halt FSM states.
package core;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] data;
        logic [31:0] seq;
    } trace_entry_t;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } trace_state_e;

    localparam int ENTRY_W = $bits(trace_entry_t);

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/core_trace_fifo.sv
// Synchronous FIFO with a valid/ready read side and an extra-MSB pointer scheme.
// A push while full still lands when the head is popped in the same cycle.
module core_trace_fifo #(
    parameter int width = 128,
    parameter int depth = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [width-1:0] wr_data,
    output logic             wr_accept,
    output logic             full,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [width-1:0] rd_data
);

    localparam int aw = $clog2(depth);

    logic [width-1:0] mem [depth];
    logic [aw:0]      wptr_reg;
    logic [aw:0]      rptr_reg;
    logic             empty;
    logic             do_pop;

    assign empty     = (wptr_reg == rptr_reg);
    assign full      = (wptr_reg[aw] != rptr_reg[aw]) &&
                       (wptr_reg[aw-1:0] == rptr_reg[aw-1:0]);
    assign rd_valid  = !empty;
    assign do_pop    = rd_valid && rd_ready;
    assign wr_accept = wr_en && (!full || do_pop);
    assign rd_data   = mem[rptr_reg[aw-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_reg <= '0;
            rptr_reg <= '0;
        end else begin
            if (wr_accept) wptr_reg <= wptr_reg + 1'b1;
            if (do_pop)    rptr_reg <= rptr_reg + 1'b1;
        end
    end

    // Storage is never reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (wr_accept) mem[wptr_reg[aw-1:0]] <= wr_data;
    end

endmodule

// File: rtl/core_trace_buf.sv
// Retirement trace buffer: queues retired instructions with a sequence number, flags
// drops, and can request a core halt after a programmed number of retirements.
module core_trace_buf
    import core::*;
#(
    parameter int          depth      = 16,
    parameter int unsigned stop_count = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    input  logic [31:0] wb_pc,
    input  logic [31:0] wb_inst,
    input  logic [31:0] wb_data,
    output logic        tr_valid,
    input  logic        tr_ready,
    output logic [31:0] tr_pc,
    output logic [31:0] tr_inst,
    output logic [31:0] tr_data,
    output logic [31:0] tr_seq,
    output logic        overflow,
    output logic        halt_req,
    input  logic        resume,
    output logic [31:0] retire_cnt
);

    localparam logic [31:0] stop_val = 32'(stop_count);
    localparam bit          halt_en  = (stop_count > 0);

    trace_state_e state_reg, state_next;
    logic [31:0]  seq_reg;
    logic [31:0]  cnt_reg, cnt_next;
    logic         overflow_reg;
    logic         fifo_full;
    logic         push_ok;
    trace_entry_t wr_entry;
    trace_entry_t head;

    assign wr_entry = '{pc: wb_pc, inst: wb_inst, data: wb_data, seq: seq_reg};

    core_trace_fifo #(
        .width (ENTRY_W),
        .depth (depth)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wb_valid),
        .wr_data   (wr_entry),
        .wr_accept (push_ok),
        .full      (fifo_full),
        .rd_valid  (tr_valid),
        .rd_ready  (tr_ready),
        .rd_data   (head)
    );

    assign tr_pc      = head.pc;
    assign tr_inst    = head.inst;
    assign tr_data    = head.data;
    assign tr_seq     = head.seq;
    assign overflow   = overflow_reg;
    assign halt_req   = (state_reg == HALTED);
    assign retire_cnt = cnt_reg;

    // Halt FSM and retirement counter; the count freezes while halted.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            RUN: begin
                if (push_ok) begin
                    cnt_next = sat_inc32(cnt_reg);
                    if (halt_en && (cnt_next == stop_val)) state_next = HALTED;
                end
            end
            HALTED: begin
                if (resume) begin
                    state_next = RUN;
                    cnt_next   = push_ok ? 32'd1 : 32'd0;
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= RUN;
            cnt_reg      <= '0;
            seq_reg      <= '0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            // Dropped retirements still consume a sequence number so gaps are visible.
            if (wb_valid) seq_reg <= seq_reg + 32'd1;
            if (wb_valid && !fifo_full) overflow_reg <= overflow_reg;
            if (wb_valid && fifo_full && !push_ok) overflow_reg <= 1'b1;
        end
    end

    // Unused-parameter guard: depth must be a power of two in 2..256.
    if (depth < 2 || depth > 256 || (depth & (depth - 1)) != 0) begin : g_bad_depth
        core_trace_buf_depth_must_be_pow2_2_to_256 u_bad ();
    end

endmodule

// File: tb/tb_core_trace_buf.sv
// Directed plus randomized checks of core_trace_buf against a queue-based reference model.
module tb_core_trace_buf;

    localparam int DEPTH = 4;
    localparam int STOP  = 3;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] data;
        logic [31:0] seq;
    } ref_entry_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_valid = 1'b0;
    logic [31:0] wb_pc = '0, wb_inst = '0, wb_data = '0;
    logic        tr_valid, tr_ready = 1'b0;
    logic [31:0] tr_pc, tr_inst, tr_data, tr_seq;
    logic        overflow, halt_req;
    logic        resume = 1'b0;
    logic [31:0] retire_cnt;

    core_trace_buf #(.depth(DEPTH), .stop_count(STOP)) dut (
        .clk        (clk),
        .rst        (rst),
        .wb_valid   (wb_valid),
        .wb_pc      (wb_pc),
        .wb_inst    (wb_inst),
        .wb_data    (wb_data),
        .tr_valid   (tr_valid),
        .tr_ready   (tr_ready),
        .tr_pc      (tr_pc),
        .tr_inst    (tr_inst),
        .tr_data    (tr_data),
        .tr_seq     (tr_seq),
        .overflow   (overflow),
        .halt_req   (halt_req),
        .resume     (resume),
        .retire_cnt (retire_cnt)
    );

    always #5 clk = ~clk;

    // Reference model state
    ref_entry_t  q[$];
    logic [31:0] m_seq = 0;
    logic        m_ovf = 0;
    logic        m_halted = 0;
    logic [31:0] m_cnt = 0;

    int passed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_outputs();
        check("tr_valid", 32'(tr_valid), 32'(q.size() > 0));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("halt_req", 32'(halt_req), 32'(m_halted));
        check("retire_cnt", retire_cnt, m_cnt);
        if (q.size() > 0) begin
            check("tr_pc", tr_pc, q[0].pc);
            check("tr_inst", tr_inst, q[0].inst);
            check("tr_data", tr_data, q[0].data);
            check("tr_seq", tr_seq, q[0].seq);
        end
    endtask

    // One clock: drive inputs, advance the model, then compare after the edge.
    task automatic cycle(input logic v, input logic r, input logic res, input logic rs,
                         input logic [31:0] pc);
        bit pop, acc;
        wb_valid = v;
        wb_pc    = pc;
        wb_inst  = $urandom;
        wb_data  = $urandom;
        tr_ready = r;
        resume   = res;
        rst      = rs;
        if (rs) begin
            q.delete();
            m_seq = 0; m_ovf = 0; m_halted = 0; m_cnt = 0;
        end else begin
            pop = (q.size() > 0) && r;
            acc = v && ((q.size() < DEPTH) || pop);
            if (pop) void'(q.pop_front());
            if (acc) q.push_back('{pc: pc, inst: wb_inst, data: wb_data, seq: m_seq});
            else if (v) m_ovf = 1;
            if (v) m_seq = m_seq + 1;
            if (m_halted) begin
                if (res) begin
                    m_halted = 0;
                    m_cnt = acc ? 1 : 0;
                end
            end else if (acc) begin
                if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
                if (STOP > 0 && m_cnt == STOP) m_halted = 1;
            end
        end
        @(posedge clk);
        #1;
        check_outputs();
        $display("cyc v=%0b rdy=%0b res=%0b rst=%0b | tr_valid=%0b seq=%0d ovf=%0b halt=%0b cnt=%0d occ=%0d",
                 v, r, res, rs, tr_valid, tr_seq, overflow, halt_req, retire_cnt, q.size());
    endtask

    initial begin
        // Reset state
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0);

        // Single push into empty FIFO: visible exactly one cycle later
        cycle(1, 0, 0, 0, 32'h0000_1000);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);

        // Fill depth-4 FIFO with pc 0,4,8,C, then a dropped 5th, then drain
        cycle(0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 32'(i * 4));
        check("full_no_ovf", 32'(overflow), 32'(0));
        cycle(1, 0, 0, 0, 32'h10);
        check("fifth_ovf", 32'(overflow), 32'(1));
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 0);

        // Full FIFO with simultaneous push and pop for 3 cycles
        cycle(0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, $urandom);
        for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, $urandom);
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, 0);

        // Halt after 3 retirements, drain while halted, resume with retirement, re-halt
        cycle(0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, $urandom);
        check("halt_after_3", 32'(halt_req), 32'(1));
        for (int i = 0; i < 2; i++) cycle(1, 1, 0, 0, $urandom);
        check("cnt_held", retire_cnt, 32'd3);
        cycle(1, 1, 1, 0, $urandom);
        check("resume_cnt", retire_cnt, 32'd1);
        cycle(0, 1, 1, 0, 0);
        for (int i = 0; i < 2; i++) cycle(1, 1, 0, 0, $urandom);
        check("rehalt", 32'(halt_req), 32'(1));

        // Reset with entries queued while halted
        cycle(0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, $urandom);
        cycle(0, 1, 0, 0, 0);
        cycle(1, 1, 1, 1, $urandom);
        check("rst_valid", 32'(tr_valid), 32'(0));

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 60) == 0), $urandom);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
